// File: rtl/image_loader.sv
// image_loader
// Receives a framed pixel stream over a valid/ready byte interface and writes
// the pixels sequentially into the 8-bit image memory write port.
// Frame on the stream: any non-sync bytes (dropped), SYNC_BYTE, IMG_PIXELS
// pixel bytes, then one checksum byte (mod-256 sum of the pixel bytes).
//
// Ports:
//   clock       - pixel-domain clock
//   reset       - synchronous, active-high
//   start       - one-cycle request to load a frame (honoured only in IDLE)
//   byte_in     - stream data
//   byte_valid  - byte_in is valid
//   byte_ready  - loader accepts a byte this cycle (registered, state only)
//   mem_address - memory write address
//   mem_data    - memory write data
//   mem_wren    - memory write enable, one cycle per pixel
//   busy        - high whenever the FSM is not in IDLE
//   done        - one-cycle pulse when a frame completes
//   error       - checksum mismatch on the last frame, sticky until next start
module image_loader #(
    parameter int          ADDR_WIDTH = 17,
    parameter int          IMG_PIXELS = 76800,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_data,
    output logic                  mem_wren,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMG_PIXELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic                  error_q, error_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;

    logic xfer;

    // ready_q is registered, so the handshake never loops back through byte_valid
    assign xfer = byte_valid & ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        error_d = error_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                    sum_d   = '0;
                    error_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (xfer && (byte_in == SYNC_BYTE)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wren_d = 1'b1;
                    addr_d = cnt_q;
                    data_d = byte_in;
                    sum_d  = sum_q + byte_in;
                    // Counter parks on the last address instead of wrapping
                    if (cnt_q == LAST_PIX) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    error_d = (byte_in != sum_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs are derived from the next state so they line up
        // with the state register.
        ready_d = (state_d == ST_SYNC) || (state_d == ST_LOAD) || (state_d == ST_CHECK);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            error_q <= error_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign byte_ready  = ready_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_wren    = wren_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a 4-pixel frame filling the whole
// 2-bit address space, so the last address doubles as the no-wrap boundary.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_image_loader;

    localparam int AW = 2;
    localparam int NP = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data;
    logic          mem_wren;
    logic          busy;
    logic          done;
    logic          error;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;   // mem_wren cycles seen by the monitor
    int n_done = 0;  // done pulses seen by the monitor

    image_loader #(
        .ADDR_WIDTH (AW),
        .IMG_PIXELS (NP),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #20 clock = ~clock;

    always @(negedge clock) begin
        if (mem_wren) n_wr++;
        if (done)     n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the transfer edge.
    task automatic send(input logic [7:0] b);
        int t;
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        while (!byte_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [7:0] b, input logic [AW-1:0] a);
        send(b);
        chk({tag, "_wren"}, mem_wren, 1);
        chk({tag, "_addr"}, mem_address, a);
        chk({tag, "_data"}, mem_data, b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // ---- reset state
        idle(3);
        chk("rst_ready", byte_ready, 0);
        chk("rst_wren",  mem_wren, 0);
        chk("rst_addr",  mem_address, 0);
        chk("rst_data",  mem_data, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        idle(2);
        chk("idle_ready", byte_ready, 0);

        // ---- 1: nominal frame, continuous valid
        n_wr = 0; n_done = 0;
        pulse_start();
        chk("s1_busy",  busy, 1);
        chk("s1_ready", byte_ready, 1);
        send(8'hA5);
        chk("s1_sync_wren", mem_wren, 0);
        pix("s1_p0", 8'h10, 2'd0);
        pix("s1_p1", 8'h20, 2'd1);
        pix("s1_p2", 8'h30, 2'd2);
        pix("s1_p3", 8'h40, 2'd3);
        send(8'hA0);
        chk("s1_ck_wren", mem_wren, 0);
        chk("s1_done",  done, 1);
        chk("s1_error", error, 0);
        chk("s1_busy_at_done", busy, 1);
        chk("s1_ready_at_done", byte_ready, 0);
        idle(1);
        chk("s1_done_fall", done, 0);
        chk("s1_busy_fall", busy, 0);
        chk("s1_nwr",   n_wr, 4);
        chk("s1_ndone", n_done, 1);

        // ---- 2: leading garbage, bad checksum
        n_wr = 0; n_done = 0;
        pulse_start();
        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        chk("s2_garbage_nwr", n_wr, 0);
        send(8'hA5);
        pix("s2_p0", 8'h01, 2'd0);
        pix("s2_p1", 8'h02, 2'd1);
        pix("s2_p2", 8'h03, 2'd2);
        pix("s2_p3", 8'h04, 2'd3);
        send(8'h0B);
        chk("s2_done",  done, 1);
        chk("s2_error", error, 1);
        idle(3);
        chk("s2_error_sticky", error, 1);
        chk("s2_nwr", n_wr, 4);

        // ---- 3: start clears error; sync value as data; sum wrap
        n_wr = 0;
        pulse_start();
        chk("s3_error_clr", error, 0);
        send(8'hA5);
        pix("s3_p0", 8'hA5, 2'd0);
        pix("s3_p1", 8'hFF, 2'd1);
        pix("s3_p2", 8'hFF, 2'd2);
        pix("s3_p3", 8'hFF, 2'd3);
        send(8'hA2);
        chk("s3_done",  done, 1);
        chk("s3_error", error, 0);
        idle(2);

        // ---- 4: valid gaps
        n_wr = 0; n_done = 0;
        pulse_start();
        send(8'hA5);
        idle(1);
        pix("s4_p0", 8'h10, 2'd0);
        chk("s4_gap0_busy", busy, 1);
        idle(1);
        chk("s4_gap0_wren", mem_wren, 0);
        pix("s4_p1", 8'h20, 2'd1);
        idle(1);
        chk("s4_gap1_wren", mem_wren, 0);
        pix("s4_p2", 8'h30, 2'd2);
        idle(1);
        pix("s4_p3", 8'h40, 2'd3);
        idle(1);
        chk("s4_gap3_wren", mem_wren, 0);
        chk("s4_gap3_done", done, 0);
        send(8'hA0);
        chk("s4_done",  done, 1);
        chk("s4_error", error, 0);
        idle(2);
        chk("s4_nwr",   n_wr, 4);
        chk("s4_ndone", n_done, 1);

        // ---- 5: reset during LOAD after two pixels
        n_wr = 0;
        pulse_start();
        send(8'hA5);
        pix("s5_p0", 8'h11, 2'd0);
        pix("s5_p1", 8'h22, 2'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("s5_rst_wren",  mem_wren, 0);
        chk("s5_rst_busy",  busy, 0);
        chk("s5_rst_ready", byte_ready, 0);
        chk("s5_rst_nwr",   n_wr, 2);
        idle(1);
        pulse_start();
        send(8'hA5);
        pix("s5_r0", 8'h10, 2'd0);
        pix("s5_r1", 8'h20, 2'd1);
        pix("s5_r2", 8'h30, 2'd2);
        pix("s5_r3", 8'h40, 2'd3);
        send(8'hA0);
        chk("s5_done",  done, 1);
        chk("s5_error", error, 0);
        idle(2);

        // ---- 6: start pulses outside IDLE are ignored
        n_wr = 0; n_done = 0;
        pulse_start();
        start = 1'b1;
        send(8'h77);          // garbage in SYNC with start high
        start = 1'b0;
        chk("s6_sync_wren", mem_wren, 0);
        send(8'hA5);
        start = 1'b1;
        pix("s6_p0", 8'h05, 2'd0);
        start = 1'b0;
        pix("s6_p1", 8'h06, 2'd1);
        pix("s6_p2", 8'h07, 2'd2);
        pix("s6_p3", 8'h08, 2'd3);   // last address, full 2-bit range
        send(8'h1A);
        chk("s6_done",  done, 1);
        chk("s6_error", error, 0);
        start = 1'b1;         // start held during DONE must not re-arm
        @(negedge clock);
        start = 1'b0;
        chk("s6_busy_after_done", busy, 0);
        idle(2);
        chk("s6_busy_idle", busy, 0);
        chk("s6_nwr",   n_wr, 4);
        chk("s6_ndone", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
